// File: rtl/instruction_queue_nbit.sv
// Instruction queue: fetches words from instruction memory or the switches into a DEPTH-entry FIFO
// feeding the decoder. Optional button synchroniser/debouncer enabled by `define IREG_DEBOUNCE_EN.
module instruction_queue_nbit #(
    parameter int                DATA_W          = 12,
    parameter int                DEPTH           = 4,
    parameter int                ADDR_W          = 8,
    parameter logic [DATA_W-1:0] IDLE_WORD       = {DATA_W{1'b1}},
    parameter int                DEBOUNCE_CYCLES = 4
) (
    input  logic                       CLK,
    input  logic                       clear_n,
    input  logic                       flush,
    input  logic                       fetch_btn,
    input  logic                       ext_btn,
    input  logic [DATA_W-1:0]          switches_data,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_req,
    input  logic                       mem_ack,
    input  logic [DATA_W-1:0]          mem_data,
    output logic [DATA_W-1:0]          instr,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_REQ  = 2'd1,
        ST_EXT_PUSH = 2'd2
    } state_t;

    state_t              state_r, state_nx_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [CNT_W-1:0]    count_r;
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [DATA_W-1:0]   fifo_r [DEPTH];
    logic [DATA_W-1:0]   stage_r;
    logic                mem_req_r, mem_req_nx_s;
    logic                drop_r, drop_nx_s;
    logic                fetch_q_r, ext_q_r;
    logic                fetch_lvl_s, ext_lvl_s;
    logic                fe_s, ee_s;
    logic                full_s, empty_s;
    logic                push_s, pop_s, stage_load_s, pc_inc_s;
    logic [DATA_W-1:0]   push_data_s;

`ifdef IREG_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]          sync1_r, sync2_r, deb_r;
    logic [DB_W-1:0]     deb_cnt_r [2];
    logic [1:0]          btn_s;

    assign btn_s = {ext_btn, fetch_btn};

    // Two-flop synchroniser followed by a stable-count debouncer per button
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            deb_r   <= 2'b00;
            for (int i = 0; i < 2; i++) deb_cnt_r[i] <= '0;
        end else begin
            sync1_r <= btn_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= '0;
                end else if (deb_cnt_r[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_r[i]     <= sync2_r[i];
                    deb_cnt_r[i] <= '0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    assign fetch_lvl_s = deb_r[0];
    assign ext_lvl_s   = deb_r[1];
`else
    assign fetch_lvl_s = fetch_btn;
    assign ext_lvl_s   = ext_btn;
`endif

    assign fe_s    = fetch_lvl_s & ~fetch_q_r;
    assign ee_s    = ext_lvl_s & ~ext_q_r;
    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == CNT_W'(0));
    assign pop_s   = ~empty_s & instr_ready & ~flush;

    // Next-state, push and drop decisions; flush overrides everything and suppresses drop
    always_comb begin
        state_nx_s   = state_r;
        mem_req_nx_s = 1'b0;
        drop_nx_s    = 1'b0;
        push_s       = 1'b0;
        push_data_s  = stage_r;
        stage_load_s = 1'b0;
        pc_inc_s     = 1'b0;
        if (flush) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fe_s | ee_s) begin
                        if (full_s | (fe_s & ee_s)) begin
                            drop_nx_s = 1'b1;
                        end else if (fe_s) begin
                            state_nx_s   = ST_MEM_REQ;
                            mem_req_nx_s = 1'b1;
                        end else begin
                            state_nx_s   = ST_EXT_PUSH;
                            stage_load_s = 1'b1;
                        end
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_MEM_REQ: begin
                    drop_nx_s = fe_s | ee_s;
                    if (mem_ack) begin
                        push_s      = 1'b1;
                        push_data_s = mem_data;
                        pc_inc_s    = 1'b1;
                        state_nx_s  = ST_IDLE;
                    end else begin
                        mem_req_nx_s = 1'b1;
                    end
                end
                ST_EXT_PUSH: begin
                    drop_nx_s  = fe_s | ee_s;
                    push_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // Control registers: state, program counter, button history, staged switch word
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            state_r   <= ST_IDLE;
            pc_r      <= '0;
            mem_req_r <= 1'b0;
            drop_r    <= 1'b0;
            fetch_q_r <= 1'b0;
            ext_q_r   <= 1'b0;
            stage_r   <= '0;
        end else begin
            state_r   <= state_nx_s;
            mem_req_r <= mem_req_nx_s;
            drop_r    <= drop_nx_s;
            fetch_q_r <= fetch_lvl_s;
            ext_q_r   <= ext_lvl_s;
            if (pc_inc_s) pc_r <= pc_r + ADDR_W'(1);
            if (stage_load_s) stage_r <= switches_data;
        end
    end

    // FIFO storage and pointers; simultaneous push and pop leave the count unchanged
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_r[i] <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign mem_addr    = pc_r;
    assign mem_req     = mem_req_r;
    assign drop        = drop_r;
    assign count       = count_r;
    assign full        = full_s;
    assign instr_valid = ~empty_s;
    assign instr       = empty_s ? IDLE_WORD : fifo_r[rd_ptr_r];

endmodule

// File: tb/tb_instruction_queue_nbit.sv
// Scoreboard bench for instruction_queue_nbit (default build, no debouncer).
module tb_instruction_queue_nbit;

    localparam int DEPTH = 4;

    logic        CLK, clear_n, flush, fetch_btn, ext_btn, mem_ack, instr_ready;
    logic [11:0] switches_data, mem_data, instr;
    logic [7:0]  mem_addr;
    logic        mem_req, instr_valid, full, drop;
    logic [2:0]  count;

    int          errors = 0;
    int          checks = 0;
    logic [11:0] exp_q [$];

    instruction_queue_nbit dut (
        .CLK(CLK), .clear_n(clear_n), .flush(flush), .fetch_btn(fetch_btn),
        .ext_btn(ext_btn), .switches_data(switches_data), .mem_addr(mem_addr),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .count(count),
        .full(full), .drop(drop)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic press_fetch();
        fetch_btn = 1'b1;
        step();
        fetch_btn = 1'b0;
    endtask

    task automatic load_ext(input logic [11:0] v);
        switches_data = v;
        ext_btn = 1'b1;
        step();
        ext_btn = 1'b0;
        step();
        exp_q.push_back(v);
    endtask

    task automatic drain(input string name);
        logic [11:0] e;
        instr_ready = 1'b1;
        for (int i = 0; i < DEPTH * 4 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (instr_valid !== 1'b1 || instr !== e) begin
                errors++;
                $display("FAIL %s_order: instr=%h valid=%b expected=%h", name, instr, instr_valid, e);
            end
            step();
        end
        instr_ready = 1'b0;
        checks++;
        if (instr !== 12'hFFF || instr_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL %s_empty: instr=%h valid=%b count=%0d expected FFF/0/0", name, instr, instr_valid, count);
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        step();
        step();
        checks++;
        if (instr !== 12'hFFF || instr_valid !== 1'b0 || full !== 1'b0 || mem_addr !== 8'h00 ||
            count !== 3'd0 || mem_req !== 1'b0 || drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: instr=%h valid=%b full=%b addr=%h count=%0d req=%b drop=%b",
                     instr, instr_valid, full, mem_addr, count, mem_req, drop);
        end
        clear_n = 1'b1;
        step();
        press_fetch();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_req: mem_req=%b expected 1", mem_req);
        end
        #2 clear_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || instr !== 12'hFFF || count !== 3'd0 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: req=%b instr=%h count=%0d addr=%h expected 0/FFF/0/00",
                     mem_req, instr, count, mem_addr);
        end
        step();
        clear_n = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        press_fetch();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL fetch_req: req=%b addr=%h expected 1/00", mem_req, mem_addr);
        end
        step();
        ext_btn = 1'b1;
        step();
        ext_btn = 1'b0;
        checks++;
        if (drop !== 1'b1 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_busy_drop: drop=%b req=%b expected 1/1", drop, mem_req);
        end
        step();
        mem_ack = 1'b1;
        mem_data = 12'hA5C;
        exp_q.push_back(12'hA5C);
        step();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || instr !== 12'hA5C || count !== 3'd1 || mem_addr !== 8'h01) begin
            errors++;
            $display("FAIL fetch_ack: req=%b instr=%h count=%0d addr=%h expected 0/A5C/1/01",
                     mem_req, instr, count, mem_addr);
        end
        press_fetch();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin
            errors++;
            $display("FAIL fetch_second_addr: req=%b addr=%h expected 1/01", mem_req, mem_addr);
        end
        mem_ack = 1'b1;
        mem_data = 12'h3C7;
        exp_q.push_back(12'h3C7);
        step();
        mem_ack = 1'b0;
        drain("fetch");
    endtask

    task automatic test_ext();
        switches_data = 12'h123;
        ext_btn = 1'b1;
        step();
        ext_btn = 1'b0;
        switches_data = 12'h000;
        checks++;
        if (instr_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL ext_latency: valid=%b count=%0d expected 0/0", instr_valid, count);
        end
        step();
        exp_q.push_back(12'h123);
        checks++;
        if (instr !== 12'h123 || count !== 3'd1 || mem_addr !== 8'h02) begin
            errors++;
            $display("FAIL ext_load: instr=%h count=%0d addr=%h expected 123/1/02", instr, count, mem_addr);
        end
        fetch_btn = 1'b1;
        ext_btn = 1'b1;
        step();
        fetch_btn = 1'b0;
        ext_btn = 1'b0;
        checks++;
        if (drop !== 1'b1 || count !== 3'd1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL ext_both_drop: drop=%b count=%0d req=%b expected 1/1/0", drop, count, mem_req);
        end
        step();
        checks++;
        if (drop !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL ext_drop_pulse: drop=%b count=%0d expected 0/1", drop, count);
        end
        drain("ext");
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) load_ext(12'(i));
        checks++;
        if (full !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: full=%b count=%0d expected 1/4", full, count);
        end
        switches_data = 12'h0EE;
        ext_btn = 1'b1;
        step();
        ext_btn = 1'b0;
        checks++;
        if (drop !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL fill_overflow_drop: drop=%b count=%0d expected 1/4", drop, count);
        end
        step();
        drain("fill");
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        load_ext(12'h005);
        load_ext(12'h006);
        switches_data = 12'h007;
        ext_btn = 1'b1;
        step();
        ext_btn = 1'b0;
        instr_ready = 1'b1;
        e = exp_q.pop_front();
        exp_q.push_back(12'h007);
        checks++;
        if (instr !== e) begin
            errors++;
            $display("FAIL b2b_head: instr=%h expected=%h", instr, e);
        end
        step();
        instr_ready = 1'b0;
        checks++;
        if (count !== 3'd2 || instr !== 12'h006) begin
            errors++;
            $display("FAIL b2b_count: count=%0d instr=%h expected 2/006", count, instr);
        end
        drain("b2b");
    endtask

    task automatic test_pc_wrap();
        int pc_model;
        pc_model = 2;
        instr_ready = 1'b1;
        while (pc_model < 255) begin
            press_fetch();
            mem_ack = 1'b1;
            mem_data = 12'(pc_model);
            step();
            mem_ack = 1'b0;
            pc_model++;
        end
        checks++;
        if (mem_addr !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_pre: addr=%h expected FF", mem_addr);
        end
        press_fetch();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_req: req=%b addr=%h expected 1/FF", mem_req, mem_addr);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        instr_ready = 1'b0;
        checks++;
        if (mem_addr !== 8'h00 || count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_pc: addr=%h count=%0d expected 00/0", mem_addr, count);
        end
    endtask

    task automatic test_flush();
        press_fetch();
        flush = 1'b1;
        mem_ack = 1'b1;
        mem_data = 12'hBAD;
        step();
        flush = 1'b0;
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || count !== 3'd0 || mem_addr !== 8'h00 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_memreq: req=%b count=%0d addr=%h valid=%b expected 0/0/00/0",
                     mem_req, count, mem_addr, instr_valid);
        end
        load_ext(12'h0A1);
        load_ext(12'h0A2);
        switches_data = 12'h0A3;
        ext_btn = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        ext_btn = 1'b0;
        exp_q.delete();
        checks++;
        if (count !== 3'd0 || drop !== 1'b0 || instr !== 12'hFFF) begin
            errors++;
            $display("FAIL flush_fifo: count=%0d drop=%b instr=%h expected 0/0/FFF", count, drop, instr);
        end
        step();
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL flush_edge_ignored: count=%0d expected 0", count);
        end
        mem_ack = 1'b1;
        mem_data = 12'h555;
        step();
        mem_ack = 1'b0;
        checks++;
        if (count !== 3'd0 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL stray_ack: count=%0d addr=%h expected 0/00", count, mem_addr);
        end
        load_ext(12'h4B2);
        drain("post_flush");
    endtask

    initial begin
        clear_n = 1'b0; flush = 1'b0; fetch_btn = 1'b0; ext_btn = 1'b0;
        switches_data = 12'h000; mem_ack = 1'b0; mem_data = 12'h000; instr_ready = 1'b0;
        test_reset();
        test_fetch();
        test_ext();
        test_fill();
        test_back_to_back();
        test_pc_wrap();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
